// File: rtl/mct_timepulse_seq.sv
// rtl/mct_timepulse_seq.sv - one-hot T01..T(NPULSE) time-pulse sequencer with run/monitor-stop/restart control
// Optional MCT_COUNTER_EN adds a 16-bit completed-MCT counter output.
module mct_timepulse_seq #(
    parameter int NPULSE = 12,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mstp,
    input  logic              step_req,
    input  logic              restart,
    output logic [NPULSE-1:0] tp,
    output logic [3:0]        tp_idx,
    output logic              mct_end,
    output logic              stopped
`ifdef MCT_COUNTER_EN
    ,
    output logic [15:0]       mct_count
`endif
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_STEP} state_t;

    localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
    localparam logic [3:0] P_LAST   = 4'(NPULSE);

    state_t            state_q, state_d;
    logic [3:0]        div_q, div_d;
    logic [3:0]        pidx_q, pidx_d;
    logic [NPULSE-1:0] tp_q, tp_d;
    logic [3:0]        tp_idx_q, tp_idx_d;
    logic              mct_end_q, mct_end_d;
    logic              stopped_q, stopped_d;
    logic              go_run;

    assign go_run = run && !mstp;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pidx_d  = pidx_q;
        if (restart) begin
            div_d   = 4'd0;
            state_d = go_run ? ST_RUN : ST_STOP;
            pidx_d  = go_run ? 4'd1 : 4'd0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (go_run) begin
                        state_d = ST_RUN;
                        div_d   = 4'd0;
                        pidx_d  = 4'd1;
                    end else if (mstp && step_req) begin
                        state_d = ST_STEP;
                        div_d   = 4'd0;
                        pidx_d  = 4'd1;
                    end
                end
                default: begin
                    if (div_q == DIV_LAST) begin
                        div_d = 4'd0;
                        // Run/mstp are only consulted here, so an MCT is never cut short.
                        if (pidx_q == P_LAST) begin
                            if (state_q == ST_RUN && go_run) begin
                                pidx_d = 4'd1;
                            end else begin
                                state_d = ST_STOP;
                                pidx_d  = 4'd0;
                            end
                        end else begin
                            pidx_d = pidx_q + 4'd1;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        tp_d = '0;
        for (int i = 0; i < NPULSE; i++) begin
            tp_d[i] = (pidx_d == 4'(i + 1));
        end
        tp_idx_d  = pidx_d;
        stopped_d = (state_d == ST_STOP);
        mct_end_d = (state_d != ST_STOP) && (pidx_d == P_LAST) && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STOP;
            div_q     <= 4'd0;
            pidx_q    <= 4'd0;
            tp_q      <= '0;
            tp_idx_q  <= 4'd0;
            mct_end_q <= 1'b0;
            stopped_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pidx_q    <= pidx_d;
            tp_q      <= tp_d;
            tp_idx_q  <= tp_idx_d;
            mct_end_q <= mct_end_d;
            stopped_q <= stopped_d;
        end
    end

    assign tp      = tp_q;
    assign tp_idx  = tp_idx_q;
    assign mct_end = mct_end_q;
    assign stopped = stopped_q;

`ifdef MCT_COUNTER_EN
    logic [15:0] mct_count_q, mct_count_d;

    always_comb begin
        mct_count_d = mct_count_q;
        if (mct_end_q) begin
            mct_count_d = mct_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mct_count_q <= 16'd0;
        end else begin
            mct_count_q <= mct_count_d;
        end
    end

    assign mct_count = mct_count_q;
`endif

endmodule

// File: tb/tb_mct_timepulse_seq.sv
// tb/tb_mct_timepulse_seq.sv - scoreboard bench for mct_timepulse_seq against a position-in-MCT model
module tb_mct_timepulse_seq;

    localparam int NPULSE = 12;
    localparam int DIV    = 2;
    localparam int MCT_LEN = NPULSE * DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run = 1'b0;
    logic              mstp = 1'b0;
    logic              step_req = 1'b0;
    logic              restart = 1'b0;
    logic [NPULSE-1:0] tp;
    logic [3:0]        tp_idx;
    logic              mct_end;
    logic              stopped;
`ifdef MCT_COUNTER_EN
    logic [15:0]       mct_count;
`endif

    mct_timepulse_seq #(.NPULSE(NPULSE), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mstp     (mstp),
        .step_req (step_req),
        .restart  (restart),
        .tp       (tp),
        .tp_idx   (tp_idx),
        .mct_end  (mct_end),
        .stopped  (stopped)
`ifdef MCT_COUNTER_EN
        ,
        .mct_count(mct_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int tp;
        int idx;
        int mend;
        int stp;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: mode 0=stopped, 1=free run, 2=single step; pos = clk index inside the MCT.
    int m_mode = 0;
    int m_pos  = 0;
    int m_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_idx();
        return (m_mode == 0) ? 0 : (m_pos / DIV + 1);
    endfunction

    task automatic drive(input logic r, input logic ru, input logic ms, input logic st, input logic rs);
        exp_t e;
        @(negedge clk);
        rst = r; run = ru; mstp = ms; step_req = st; restart = rs;
        if (m_mode != 0 && m_pos == MCT_LEN - 1) m_cnt = (m_cnt + 1) % 65536;
        if (r) begin
            m_mode = 0; m_pos = 0; m_cnt = 0;
        end else if (rs) begin
            m_pos  = 0;
            m_mode = (ru && !ms) ? 1 : 0;
        end else if (m_mode == 0) begin
            if (ru && !ms) begin
                m_mode = 1; m_pos = 0;
            end else if (ms && st) begin
                m_mode = 2; m_pos = 0;
            end
        end else if (m_pos == MCT_LEN - 1) begin
            m_pos = 0;
            if (!(m_mode == 1 && ru && !ms)) m_mode = 0;
        end else begin
            m_pos++;
        end
        e.idx  = model_idx();
        e.tp   = (e.idx == 0) ? 0 : (1 << (e.idx - 1));
        e.mend = (m_mode != 0 && m_pos == MCT_LEN - 1) ? 1 : 0;
        e.stp  = (m_mode == 0) ? 1 : 0;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tp", int'(tp), e.tp);
                check("tp_idx", int'(tp_idx), e.idx);
                check("mct_end", int'(mct_end), e.mend);
                check("stopped", int'(stopped), e.stp);
                check("stopped_iff_tp_zero", int'(stopped), int'(tp == '0));
`ifdef MCT_COUNTER_EN
                check("mct_count", int'(mct_count), e.cnt);
`endif
            end
        end
    end

    task automatic run_until_idx(input int idx, input logic ru, input logic ms);
        int n = 0;
        while (model_idx() != idx && n < 200) begin
            drive(1'b0, ru, ms, 1'b0, 1'b0);
            n++;
        end
        check("reach_idx_within_bound", model_idx(), idx);
    endtask

    initial begin : stimulus
        int budget;
        logic ru, ms;
        // Reset and free run across an MCT wrap.
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0);
        repeat (MCT_LEN + 6) drive(0, 1, 0, 0, 0);
        // Graceful stop: drop run during T05.
        run_until_idx(5, 1, 0);
        repeat (MCT_LEN) drive(0, 0, 0, 0, 0);
        // Single step with an ignored second request.
        drive(0, 1, 1, 1, 0);
        repeat (10) drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 1, 0);
        repeat (MCT_LEN + 4) drive(0, 1, 1, 0, 0);
        // Restart during T07 while free running.
        run_until_idx(7, 1, 0);
        drive(0, 1, 0, 0, 1);
        repeat (MCT_LEN + 3) drive(0, 1, 0, 0, 0);
        // Restart mid-STEP.
        repeat (MCT_LEN + 2) drive(0, 1, 1, 0, 0);
        drive(0, 0, 1, 1, 0);
        repeat (8) drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 1);
        repeat (3) drive(0, 0, 1, 0, 0);
        // Reset during T09.
        run_until_idx(9, 1, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // Restart and step_req together while stopped in monitor-stop.
        drive(0, 0, 1, 1, 1);
        repeat (4) drive(0, 0, 1, 0, 0);
`ifdef MCT_COUNTER_EN
        repeat (3 * MCT_LEN) drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0);
`endif
        // Randomized control traffic.
        ru = 1'b1; ms = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ru = ~ru;
            if ($urandom_range(0, 29) == 0) ms = ~ms;
            drive(($urandom_range(0, 199) == 0), ru, ms,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
        end
        drive(0, 0, 0, 0, 0);
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mct_timepulse_seq.md
Name: mct_timepulse_seq

Overview:
- Sequencer that generates the one-hot time-pulse train T01..T12 for each memory cycle time (MCT).
- It is the block that clocks and sequences the gate-level datapath built from the `nor_*` primitives.
- Supports free-run, monitor-stop (MSTP) single-MCT stepping and restart (GOJAM-style) resynchronisation.
- Sits between the master clock and the timing-gate network. All outputs are registered.

Parameters:
- NPULSE, 12, number of time pulses per MCT (legal 2..15).
- DIV, 2, clk cycles each time pulse is held (legal 1..16).

Ports:
- clk  input  1  master clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; enables continuous MCT sequencing.
- mstp  input  1  level; monitor stop, selects single-step mode.
- step_req  input  1  one-cycle pulse; request exactly one MCT while stopped.
- restart  input  1  one-cycle pulse; abort current MCT and resync to T01.
- tp  output  NPULSE  one-hot time pulse; bit 0 = T01; all-zero when stopped.
- tp_idx  output  4  index of active pulse, 1..NPULSE; 0 when stopped.
- mct_end  output  1  one-cycle pulse on the last clk of T(NPULSE).
- stopped  output  1  high while the sequencer is halted.

Behaviour:
- State machine:
  - States are STOP, RUN and STEP.
  - There is a divider counter `div` (0..DIV-1) and a pulse counter `pidx` (1..NPULSE).
- Reset:
  - Forces state=STOP, div=0, pidx=0, tp=0, tp_idx=0, mct_end=0, stopped=1.
  - `rst` has priority over every other input, including when asserted mid-MCT.
- STOP:
  - If run=1 and mstp=0, go to RUN. In the next cycle tp=T01, tp_idx=1, stopped=0.
  - Else if mstp=1 and step_req=1, go to STEP. T01 appears in the next cycle.
  - step_req is ignored when mstp=0 or when the state is not STOP. Ignored requests are not queued.
- Pulse advance (RUN and STEP):
  - div increments each clk.
  - At div=DIV-1, div wraps to 0 and pidx advances by 1.
  - Each pulse therefore lasts exactly DIV cycles. There is never a gap or overlap between pulses; tp is always one-hot or zero.
- End of MCT:
  - On the cycle with pidx=NPULSE and div=DIV-1, mct_end=1 for exactly that cycle.
  - RUN:
    - If run=1 and mstp=0 at that cycle, wrap to T01 with no idle cycle.
    - Otherwise go to STOP; tp=0 and stopped=1 on the next cycle.
  - STEP always goes to STOP after one MCT.
- Mid-MCT changes:
  - Deasserting run or asserting mstp never truncates the current MCT. The condition is sampled only at mct_end.
- restart:
  - Takes priority below rst and above all other inputs.
  - div and pidx are cleared. mct_end is not pulsed for the aborted MCT.
  - If run=1 and mstp=0, the next cycle shows T01 in RUN.
  - Otherwise go to STOP with tp=0. This also applies if the sequencer was in STEP.
  - restart while in STOP with run=0 has no effect other than remaining stopped.
- Simultaneous events:
  - restart and step_req in the same cycle: restart wins and step_req is dropped.
- Latency:
  - From the start condition to T01 is 1 clk.
  - One MCT is NPULSE×DIV clks.
- Invariants:
  - stopped=1 if and only if tp==0.
  - tp_idx equals the 1-based position of the set bit in tp.

Optional Feature:
- Macro: MCT_COUNTER_EN.
- When defined:
  - Adds output `mct_count[15:0]`, incremented on every mct_end cycle.
  - It wraps from 0xFFFF to 0.
  - It is cleared by rst only; restart does not clear it.
- When undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Free run (DIV=2, NPULSE=12):
  - Stimulus: rst 2 cycles, then run=1, mstp=0.
  - Required: T01 at cycle 1 after rst release; tp_idx walks 1..12, each pulse held 2 cycles; mct_end high on cycle 24; T01 again on cycle 25 with no gap.
- Graceful stop:
  - Stimulus: drop run during T05.
  - Required: sequence continues through T12, mct_end pulses, then tp=0 and stopped=1 on the following cycle.
- Single step:
  - Stimulus: mstp=1, run=1, one step_req pulse.
  - Required: exactly one MCT of 24 cycles, one mct_end, then STOP.
  - Stimulus: step_req during that MCT.
  - Required: ignored, no second MCT.
- Restart:
  - Stimulus: restart pulse during T07 while run=1.
  - Required: next cycle T01 with div=0; no mct_end for the aborted MCT.
  - Stimulus: restart with mstp=1 mid-STEP.
  - Required: tp=0 on the next cycle.
- Reset mid-MCT and priority:
  - Stimulus: rst during T09.
  - Required: tp=0, stopped=1, tp_idx=0 on the next cycle.
  - Stimulus: restart and step_req together in STOP with mstp=1.
  - Required: no MCT starts.
- MCT_COUNTER_EN:
  - Stimulus: 3 full MCTs, then restart.
  - Required: mct_count=3, unchanged by restart.
  - Stimulus: preload near wrap by running 65536 MCTs.
  - Required: mct_count=0.
